// File: rtl/riscv_mem_pkg.sv
// Shared memory-side definitions for the load extender and the store unit:
// funct3 encodings, store FSM states and base byte strobes.
package riscv_mem_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } store_state_t;

endpackage

// File: rtl/store_unit_if.sv
// Data-memory write port: one beat transfers when mem_valid && mem_ready.
interface store_unit_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_ready);
  modport slave  (input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_ready);
endinterface

// File: rtl/store_align.sv
// Combinational lane alignment: spreads a SB/SH/SW over an 8-byte window
// starting at the word containing the store address.
module store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  mask8,
  output logic [63:0] data64,
  output logic        needs_beat1,
  output logic        illegal
);

  logic [3:0]  base;
  logic [31:0] lanes;

  always_comb begin
    base    = '0;
    lanes   = '0;
    illegal = 1'b0;
    case (funct3)
      F3_SB: begin base = STRB_B; lanes = {24'b0, data[7:0]};  end
      F3_SH: begin base = STRB_H; lanes = {16'b0, data[15:0]}; end
      F3_SW: begin base = STRB_W; lanes = data;                end
      default: illegal = 1'b1;
    endcase
    // Unused bytes are cleared before shifting so disabled lanes stay zero.
    mask8       = {4'b0000, base} << off;
    data64      = {32'b0, lanes} << {off, 3'b000};
    needs_beat1 = |mask8[7:4];
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one SB/SH/SW and emits one or two word-aligned
// memory write beats, then pulses done (or err if the store is rejected).
module store_unit
  import riscv_mem_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        data,
  store_unit_if.master       mem,
  output logic               done,
  output logic               err
);

  store_state_t state, state_n;

  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic [3:0]  wstrb_q, wstrb_n;
  logic [31:0] hi_wdata_q, hi_wdata_n;
  logic [3:0]  hi_wstrb_q, hi_wstrb_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        needs_beat1;
  logic        illegal;
  logic        reject;

  store_align u_align (
    .funct3      (funct3),
    .off         (addr[1:0]),
    .data        (data),
    .mask8       (mask8),
    .data64      (data64),
    .needs_beat1 (needs_beat1),
    .illegal     (illegal)
  );

  assign reject    = illegal || (needs_beat1 && !ALLOW_MISALIGNED);
  assign req_ready = (state == IDLE) && !rst;

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    wstrb_n    = wstrb_q;
    hi_wdata_n = hi_wdata_q;
    hi_wstrb_n = hi_wstrb_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (reject) begin
            err_n = 1'b1;
          end else begin
            state_n    = BEAT0;
            addr_n     = {addr[31:2], 2'b00};
            wstrb_n    = mask8[3:0];
            wdata_n    = data64[31:0];
            hi_wstrb_n = mask8[7:4];
            hi_wdata_n = data64[63:32];
          end
        end
      end
      BEAT0: begin
        if (mem.mem_ready) begin
          // A non-empty upper strobe is what marks a word-crossing store.
          if (hi_wstrb_q != 4'b0000) begin
            state_n = BEAT1;
            addr_n  = addr_q + 32'd4;
            wstrb_n = hi_wstrb_q;
            wdata_n = hi_wdata_q;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem.mem_ready) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      hi_wdata_q <= '0;
      hi_wstrb_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      wstrb_q    <= wstrb_n;
      hi_wdata_q <= hi_wdata_n;
      hi_wstrb_q <= hi_wstrb_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  assign mem.mem_valid = (state != IDLE);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed corner stores plus random
// stores compared against a byte-by-byte reference model.
module tb_store_unit;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid1 = 1'b0;
  logic        req_ready, req_ready1;
  logic        done, done1, err, err1;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  store_unit_if bus ();
  store_unit_if bus1 ();

  store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .funct3    (funct3),
    .addr      (addr),
    .data      (data),
    .mem       (bus),
    .done      (done),
    .err       (err)
  );

  store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .funct3    (funct3),
    .addr      (addr),
    .data      (data),
    .mem       (bus1),
    .done      (done1),
    .err       (err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: place each stored byte individually at its own byte address.
  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       output int n, output logic [31:0] ea0, output logic [31:0] ea1,
                       output logic [31:0] ed0, output logic [31:0] ed1,
                       output logic [3:0] es0, output logic [3:0] es1);
    int size;
    logic [31:0] ba, w;
    logic [7:0]  b;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    ea0 = a & 32'hFFFF_FFFC;
    ea1 = ea0 + 32'd4;
    ed0 = '0; ed1 = '0; es0 = '0; es1 = '0;
    n = 1;
    for (int i = 0; i < size; i++) begin
      ba = a + i;
      w  = ba & 32'hFFFF_FFFC;
      b  = 8'((d >> (8 * i)) & 32'hFF);
      if (w == ea0) begin
        ed0 = ed0 | (32'(b) << (8 * ba[1:0]));
        es0[ba[1:0]] = 1'b1;
      end else begin
        ed1 = ed1 | (32'(b) << (8 * ba[1:0]));
        es1[ba[1:0]] = 1'b1;
        n = 2;
      end
    end
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int stall_lo, input int stall_hi, input int rst_beat);
    int n, k;
    logic [31:0] ea[2], ed[2];
    logic [3:0]  es[2];
    model(f3, a, d, n, ea[0], ea[1], ed[0], ed[1], es[0], es[1]);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    funct3 = f3; addr = a; data = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    funct3 = 3'($urandom); addr = $urandom; data = $urandom;
    if (f3 > 3'd2) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_no_valid", 32'(bus.mem_valid), 32'd0);
      chk("err_no_done", 32'(done), 32'd0);
      chk("err_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      chk("err_one_cycle", 32'(err), 32'd0);
      return;
    end
    for (int b = 0; b < n; b++) begin
      k = $urandom_range(stall_hi, stall_lo);
      if (rst_beat == b && k < 1) k = 1;
      chk("busy_no_done", 32'(done), 32'd0);
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      for (int s = 0; s <= k; s++) begin
        chk("beat_valid", 32'(bus.mem_valid), 32'd1);
        chk("beat_addr", bus.mem_addr, ea[b]);
        chk("beat_wdata", bus.mem_wdata, ed[b]);
        chk("beat_wstrb", 32'(bus.mem_wstrb), 32'(es[b]));
        if (s == k) break;
        bus.mem_ready = 1'b0;
        if (rst_beat == b) begin
          rst = 1'b1;
          @(negedge clk);
          chk("rst_valid", 32'(bus.mem_valid), 32'd0);
          chk("rst_done", 32'(done), 32'd0);
          chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
          chk("rst_req_ready_low", 32'(req_ready), 32'd0);
          rst = 1'b0;
          @(negedge clk);
          chk("post_rst_req_ready", 32'(req_ready), 32'd1);
          chk("post_rst_valid", 32'(bus.mem_valid), 32'd0);
          chk("post_rst_done", 32'(done), 32'd0);
          return;
        end
        @(negedge clk);
      end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_no_err", 32'(err), 32'd0);
    chk("done_valid_low", 32'(bus.mem_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra;
    bus.mem_ready  = 1'b0;
    bus1.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(bus.mem_valid), 32'd0);
    chk("reset_addr", bus.mem_addr, 32'd0);
    chk("reset_wdata", bus.mem_wdata, 32'd0);
    chk("reset_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    run_store(F3_SB, 32'h0000_0103, 32'hAABB_CCDD, 0, 0, -1);
    run_store(F3_SW, 32'h0000_1002, 32'h1122_3344, 0, 0, -1);
    run_store(F3_SH, 32'h0000_0020, 32'hFFFF_8765, 3, 3, -1);
    run_store(3'b011, 32'h0000_0040, 32'h1234_5678, 0, 0, -1);
    run_store(F3_SW, 32'hFFFF_FFFF, 32'hCAFE_BABE, 0, 0, -1);
    run_store(F3_SW, 32'hFFFF_FFFF, 32'hCAFE_BABE, 1, 2, 1);
    run_store(F3_SW, 32'h0000_0002, 32'h5566_7788, 1, 3, 0);

    // Strict instance: word-crossing SH is rejected, aligned SW goes through.
    @(negedge clk);
    funct3 = F3_SH; addr = 32'h0000_0007; data = 32'h0000_ABCD; req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("strict_err", 32'(err1), 32'd1);
    chk("strict_no_valid", 32'(bus1.mem_valid), 32'd0);
    chk("strict_req_ready", 32'(req_ready1), 32'd1);
    @(negedge clk);
    chk("strict_err_one_cycle", 32'(err1), 32'd0);
    funct3 = F3_SW; addr = 32'h0000_0300; data = 32'hDEAD_BEEF; req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("strict_aligned_valid", 32'(bus1.mem_valid), 32'd1);
    chk("strict_aligned_addr", bus1.mem_addr, 32'h0000_0300);
    chk("strict_aligned_wdata", bus1.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("strict_aligned_done", 32'(done1), 32'd1);
    chk("strict_aligned_err", 32'(err1), 32'd0);

    for (int i = 0; i < 60; i++) begin
      rf3 = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2, 0));
      ra  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(3, 0))) : $urandom;
      run_store(rf3, ra, $urandom, 0, 3, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
